dmem_access_ctrl: RTL and testbench

Two-port access controller in front of the byte-addressed data memory of the multi-cycle CPU. It arbitrates between the CPU load/store port (p0) and a debug/DMA port (p1), and checks each request for alignment, width and range. It sequences exactly one memory access per transaction and returns the read data or an error to the requester. It drives the data memory's write-enable, width, sign, address and write-data inputs and samples its combinational read-data output.

---
 rtl/dmem_access_ctrl.sv | 135 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Two-port data-memory access controller: arbitrates p0/p1, checks alignment/width/range, runs one access per
// transaction (ack in cycle 1, done in cycle 2, one transaction per 3 cycles); requesters hold req until ack.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_LIMIT = 1024,
  parameter bit          FAIR       = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_width,
  input  logic        p0_sign,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_done,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_width,
  input  logic        p1_sign,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_done,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_we,
  output logic [1:0]  mem_width,
  output logic        mem_sign,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  width;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_sel, req_q;
  logic        grant, port_q, last_q;
  logic        err_sel, err_q;
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic [31:0] p0_rdata_q, p1_rdata_q;
  logic        p0_err_q, p1_err_q;

  // grant: 0 selects p0, 1 selects p1; only meaningful when some req is high
  always_comb begin
    grant = p1_req;
    if (p0_req && p1_req) grant = FAIR ? ~last_q : 1'b0;
    req_sel = grant ? {p1_we, p1_width, p1_sign, p1_addr, p1_wdata}
                    : {p0_we, p0_width, p0_sign, p0_addr, p0_wdata};
    case (req_sel.width)
      2'b01:   nbytes = 3'd2;
      2'b11:   nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
    // 33-bit end address so that wrap past 0xFFFFFFFF is caught as out of range
    end_addr = {1'b0, req_sel.addr} + {30'd0, nbytes} - 33'd1;
    err_sel  = (req_sel.width == 2'b10)
             | ((req_sel.width == 2'b01) & req_sel.addr[0])
             | ((req_sel.width == 2'b11) & (req_sel.addr[1:0] != 2'b00))
             | (end_addr >= 33'(ADDR_LIMIT));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (p0_req || p1_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      port_q     <= 1'b0;
      last_q     <= 1'b1;
      err_q      <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
      p0_err_q   <= 1'b0;
      p1_err_q   <= 1'b0;
    end else begin
      if (state == IDLE && (p0_req || p1_req)) begin
        req_q  <= req_sel;
        port_q <= grant;
        last_q <= grant;
        err_q  <= err_sel;
      end
      // stores and rejected requests report zero data
      if (state == ACCESS) begin
        if (port_q) begin
          p1_rdata_q <= (req_q.we || err_q) ? 32'd0 : mem_rdata;
          p1_err_q   <= err_q;
        end else begin
          p0_rdata_q <= (req_q.we || err_q) ? 32'd0 : mem_rdata;
          p0_err_q   <= err_q;
        end
      end
    end
  end

  assign p0_ack   = (state == ACCESS) & ~port_q;
  assign p1_ack   = (state == ACCESS) &  port_q;
  assign p0_done  = (state == RESP)   & ~port_q;
  assign p1_done  = (state == RESP)   &  port_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign p0_err   = p0_err_q;
  assign p1_err   = p1_err_q;

  assign mem_we    = (state == ACCESS) & req_q.we & ~err_q;
  assign mem_width = req_q.width;
  assign mem_sign  = req_q.sign;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-array memory model, vector table of single transactions,
// arbitration runs on a fair and a fixed-priority instance, and reset during a store.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p0_sign, p1_req, p1_we, p1_sign;
  logic [1:0]  p0_width, p1_width;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_done, p0_err, p1_ack, p1_done, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we, mem_sign;
  logic [1:0]  mem_width;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        fp0_req, fp1_req;
  logic        fp0_ack, fp0_done, fp0_err, fp1_ack, fp1_done, fp1_err;
  logic [31:0] fp0_rdata, fp1_rdata;
  logic        fmem_we, fmem_sign;
  logic [1:0]  fmem_width;
  logic [31:0] fmem_addr, fmem_wdata;

  logic [7:0]  mem [1024];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_LIMIT(1024), .FAIR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_width(p0_width), .p0_sign(p0_sign),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_width(p1_width), .p1_sign(p1_sign),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_width(mem_width), .mem_sign(mem_sign),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_access_ctrl #(.ADDR_LIMIT(1024), .FAIR(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(fp0_req), .p0_we(p0_we), .p0_width(p0_width), .p0_sign(p0_sign),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(fp0_ack), .p0_done(fp0_done), .p0_rdata(fp0_rdata), .p0_err(fp0_err),
    .p1_req(fp1_req), .p1_we(p1_we), .p1_width(p1_width), .p1_sign(p1_sign),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(fp1_ack), .p1_done(fp1_done), .p1_rdata(fp1_rdata), .p1_err(fp1_err),
    .mem_we(fmem_we), .mem_width(fmem_width), .mem_sign(fmem_sign),
    .mem_addr(fmem_addr), .mem_wdata(fmem_wdata), .mem_rdata(32'd0)
  );

  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] w, input logic s);
    logic [9:0] i;
    logic [7:0] b0, b1, b2, b3;
    i  = a[9:0];
    b0 = mem[i];
    b1 = mem[i + 10'd1];
    b2 = mem[i + 10'd2];
    b3 = mem[i + 10'd3];
    case (w)
      2'b00:   return s ? {{24{b0[7]}}, b0} : {24'd0, b0};
      2'b01:   return s ? {{16{b1[7]}}, b1, b0} : {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  assign mem_rdata = mem_read(mem_addr, mem_width, mem_sign);

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[9:0]] <= mem_wdata[7:0];
      if (mem_width != 2'b00) mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
      if (mem_width == 2'b11) begin
        mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
        mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  width;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [19];
  logic [31:0] model_rd [2];
  logic        model_err [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if (v.port) begin
      p1_we = v.we; p1_width = v.width; p1_sign = v.sign; p1_addr = v.addr; p1_wdata = v.wdata; p1_req = 1'b1;
    end else begin
      p0_we = v.we; p0_width = v.width; p0_sign = v.sign; p0_addr = v.addr; p0_wdata = v.wdata; p0_req = 1'b1;
    end
  endtask

  // starts on a negedge; accept edge ends cycle 0, ack in cycle 1, done in cycle 2, idle in cycle 3
  task automatic do_txn(input vec_t v, input string tag);
    logic o;
    o = ~v.port;
    drive(v);
    @(negedge clk);
    chk({tag, " ack"},       v.port ? p1_ack : p0_ack, 32'd1);
    chk({tag, " other ack"}, v.port ? p0_ack : p1_ack, 32'd0);
    chk({tag, " mem_we"},    mem_we, {31'd0, v.we & ~v.exp_err});
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
    chk({tag, " done"},       v.port ? p1_done : p0_done, 32'd1);
    chk({tag, " other done"}, v.port ? p0_done : p1_done, 32'd0);
    chk({tag, " rdata"},      v.port ? p1_rdata : p0_rdata, v.exp_rdata);
    chk({tag, " err"},        v.port ? p1_err : p0_err, {31'd0, v.exp_err});
    chk({tag, " mem_we resp"}, mem_we, 32'd0);
    model_rd[v.port]  = v.exp_rdata;
    model_err[v.port] = v.exp_err;
    @(negedge clk);
    chk({tag, " done clears"}, v.port ? p1_done : p0_done, 32'd0);
    chk({tag, " other rdata held"}, o ? p1_rdata : p0_rdata, model_rd[o]);
    chk({tag, " other err held"},   o ? p1_err : p0_err, {31'd0, model_err[o]});
  endtask

  // both ports request 4 loads each; grant order recorded from the acks
  task automatic arb_run(input bit fp, input logic [7:0] exp_seq, input string tag);
    int n, rem0, rem1, cyc;
    logic [7:0] seq;
    logic a0, a1;
    n = 0; rem0 = 4; rem1 = 4; cyc = 0; seq = '0;
    p0_we = 1'b0; p1_we = 1'b0; p0_width = 2'b11; p1_width = 2'b11;
    p0_sign = 1'b0; p1_sign = 1'b0; p0_addr = 32'h0; p1_addr = 32'h4;
    if (fp) begin fp0_req = 1'b1; fp1_req = 1'b1; end
    else    begin p0_req = 1'b1;  p1_req = 1'b1;  end
    while (n < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      a0 = fp ? fp0_ack : p0_ack;
      a1 = fp ? fp1_ack : p1_ack;
      if (a0) begin
        seq[n[2:0]] = 1'b0; n++; rem0--;
        if (rem0 == 0) begin if (fp) fp0_req = 1'b0; else p0_req = 1'b0; end
      end else if (a1) begin
        seq[n[2:0]] = 1'b1; n++; rem1--;
        if (rem1 == 0) begin if (fp) fp1_req = 1'b0; else p1_req = 1'b0; end
      end
    end
    p0_req = 1'b0; p1_req = 1'b0; fp0_req = 1'b0; fp1_req = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, " grant count"}, 32'(n), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s grant %0d", tag, i), {31'd0, seq[i]}, {31'd0, exp_seq[i]});
  endtask

  initial begin
    logic seen_done;
    vec_t rv;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    model_rd[0] = '0; model_rd[1] = '0; model_err[0] = 1'b0; model_err[1] = 1'b0;

    //            port  we    width  sign  addr           wdata          exp_rdata      err
    vecs[0]  = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0040, 32'h1122_3344, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h1234_5680, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0021, 32'h0,         32'hFFFF_FF80, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0021, 32'h0,         32'h0000_0080, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0020, 32'h0000_005A, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'h0,         32'hFFFF_805A, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h0000_FFFF, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_03FE, 32'h0102_0304, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_03FE, 32'h0,         32'h0000_CAFE, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_03FF, 32'h0,         32'hFFFF_FFCA, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0,         32'h1122_3344, 1'b0};

    rst_n = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_width = 2'b00; p0_sign = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_width = 2'b00; p1_sign = 1'b0; p1_addr = '0; p1_wdata = '0;
    fp0_req = 1'b0; fp1_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset p0_ack",   p0_ack, 32'd0);
    chk("reset p1_done",  p1_done, 32'd0);
    chk("reset p0_rdata", p0_rdata, 32'd0);
    chk("reset p1_err",   p1_err, 32'd0);
    chk("reset mem_we",   mem_we, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    arb_run(1'b0, 8'b1010_1010, "fair");
    arb_run(1'b1, 8'b1111_0000, "fixed");

    for (int i = 0; i < 18; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // store to 0x40 interrupted by reset while the memory is being driven
    rv = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0040, 32'h5566_7788, 32'h0, 1'b0};
    drive(rv);
    @(negedge clk);
    chk("rst-mid ack",    p0_ack, 32'd1);
    chk("rst-mid mem_we", mem_we, 32'd1);
    p0_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst-mid mem_we drop", mem_we, 32'd0);
    chk("rst-mid p0_ack",      p0_ack, 32'd0);
    chk("rst-mid p0_done",     p0_done, 32'd0);
    chk("rst-mid p0_rdata",    p0_rdata, 32'd0);
    chk("rst-mid p1_rdata",    p1_rdata, 32'd0);
    chk("rst-mid p1_err",      p1_err, 32'd0);
    chk("rst-mid mem_addr",    mem_addr, 32'd0);
    chk("rst-mid mem_wdata",   mem_wdata, 32'd0);
    chk("rst-mid mem_width",   {30'd0, mem_width}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_rd[0] = '0; model_rd[1] = '0; model_err[0] = 1'b0; model_err[1] = 1'b0;
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_done = seen_done | p0_done | p1_done;
    end
    chk("rst-mid no done", {31'd0, seen_done}, 32'd0);
    do_txn(vecs[18], "post-reset load");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
